regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised multi-port general-purpose register file with an integrated per-register busy scoreboard and optional write-to-read bypass. It is the next-generation GPR store for the NPC core: decode reads operands through NREAD ports and reserves destinations through the allocate port, while writeback retires results through NWRITE ports. Register 0 is hardwired to zero. All state clears on reset.

## Interface
- REG_NUM, default 32: number of architectural registers; power of two, ≥ 2.
- ADDR_WIDTH, default 5: register address width; equals log2(REG_NUM).
- DATA_WIDTH, default 64: register width.
- NREAD, default 2: number of read ports, 1..4.
- NWRITE, default 1: number of write ports, 1..2.
- BYPASS, default 1: 1 = same-cycle write data and busy-clear forwarded to reads; 0 = reads see registered state only.
- clk  in  1  the single clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- raddr  in  NREAD*ADDR_WIDTH  read addresses; port i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- rdata  out  NREAD*DATA_WIDTH  read data, combinational, same slicing.
- rready  out  NREAD  1 = the addressed register is not busy, so its operand is valid.
- wen  in  NWRITE  per-port write enable.
- waddr  in  NWRITE*ADDR_WIDTH  write addresses.
- wdata  in  NWRITE*DATA_WIDTH  write data.
- alloc_en  in  1  request to mark alloc_addr busy (destination reservation).
- alloc_addr  in  ADDR_WIDTH  register to reserve.
- alloc_ready  out  1  1 = reservation accepted this cycle if alloc_en is high.
- flush  in  1  synchronous clear of all busy bits (pipeline squash).

## Operation
- Storage: REG_NUM×DATA_WIDTH array plus REG_NUM busy bits. Entry 0 always reads 0 and is never busy. Writes and allocations to address 0 are ignored; alloc_ready is 1 for address 0.
- Write: on a clock edge, each port with wen[j]=1 and waddr≠0 stores wdata[j]. If two ports target the same address, the higher-index port wins.
- Any accepted write clears busy[waddr]. A write to a non-busy register is legal and only updates data.
- Allocate: alloc_ready = !busy[alloc_addr], based on registered state only, with no forwarding of same-cycle writeback. When alloc_en && alloc_ready && alloc_addr≠0, busy[alloc_addr] is set at the edge. When alloc_en && !alloc_ready, the request is dropped; the requester must hold and retry.
- Same-edge alloc set and writeback clear on one register: set wins, so busy stays 1 (the new producer owns it).
- flush: all busy bits clear at the edge. flush beats a same-cycle allocate, which is not recorded. Data writes in the flush cycle still commit.
- Read, BYPASS=0:
  - rdata[i] = array[raddr[i]]
  - rready[i] = !busy[raddr[i]]
- Read, BYPASS=1: if any wen[j] has waddr[j]==raddr[i]≠0, then rdata[i] = wdata of the highest such j, and rready[i]=1. Otherwise the BYPASS=0 behaviour applies.
- Address 0 read: rdata=0, rready=1, regardless of writes.
- Reset (rst_n=0, asynchronous):
  - all registers = 0; all busy = 0.
  - Outputs under reset: rdata=0 on every port; rready all 1; alloc_ready=1.
  - Writes and allocations presented while rst_n=0 are ignored.
  - Reset release takes effect at the next rising edge.

## Timing
- Read path is purely combinational from raddr, plus wen/waddr/wdata when BYPASS=1. Latency is 0 cycles.
- Write latency: data is visible in the registered array 1 cycle after the edge. With BYPASS=1 it is also visible in the write cycle itself.
- Busy set latency: the allocate accepted at edge N gives rready=0 for that register from cycle N+1.
- Busy clear latency: writeback at edge N gives rready=1 from cycle N+1. With BYPASS=1 the clear is also visible in cycle N.
- No multi-cycle states; scoreboard state per register is {IDLE, BUSY}:
  - IDLE→BUSY on accepted alloc.
  - BUSY→IDLE on write or flush.
  - BUSY→BUSY on simultaneous write+alloc.
- Reset mid-operation: an in-flight allocate or write in the reset cycle is discarded; busy bits and data are cleared immediately.

## Test plan
- Reset: hold rst_n=0, then raise it.
  - Required: all 32 registers read 0; all rready=1; alloc_ready=1.
  - Then assert rst_n=0 asynchronously mid-cycle after writing x5=0x1234. Required: rdata(x5)=0 with no clock edge.
- Write/read and x0:
  - Write x7=0xDEAD_BEEF, then read x7 on both ports → 0xDEAD_BEEF both.
  - Write x0=0xFFFF → x0 reads 0.
- Bypass (BYPASS=1):
  - In the same cycle, write x3=0x55 and read x3 → rdata=0x55, rready=1.
  - With BYPASS=0 → the old value 0 is returned until the next cycle.
- Scoreboard:
  - Alloc x9 → next cycle rready(x9)=0 and alloc_ready for x9 is 0; a second alloc x9 is dropped.
  - Write x9=0x42 → next cycle rready=1 with data 0x42.
- Simultaneous events:
  - Same edge, alloc x4 (idle) + write x4=0x11 → busy(x4)=1, data=0x11.
  - NWRITE=2, both ports write x6 with 0xA and 0xB → x6=0xB.
- Flush:
  - Alloc x1, x2, x3 over three cycles, then flush together with alloc x10 → all rready=1 and x10 not busy next cycle.

Source files
------------

// File: rtl/regfile_sb.sv
// regfile_sb: multi-port GPR file with per-register busy scoreboard and optional write-to-read bypass
module regfile_sb #(
  parameter int REG_NUM    = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64,
  parameter int NREAD      = 2,
  parameter int NWRITE     = 1,
  parameter int BYPASS     = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NREAD*ADDR_WIDTH-1:0]  raddr,
  output logic [NREAD*DATA_WIDTH-1:0]  rdata,
  output logic [NREAD-1:0]             rready,
  input  logic [NWRITE-1:0]            wen,
  input  logic [NWRITE*ADDR_WIDTH-1:0] waddr,
  input  logic [NWRITE*DATA_WIDTH-1:0] wdata,
  input  logic                         alloc_en,
  input  logic [ADDR_WIDTH-1:0]        alloc_addr,
  output logic                         alloc_ready,
  input  logic                         flush
);
  logic [DATA_WIDTH-1:0] mem [REG_NUM];
  logic [REG_NUM-1:0]    busy;
  assign alloc_ready = !busy[alloc_addr];
  // later write ports override earlier ones; the alloc set is applied last so it beats a writeback clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < REG_NUM; k++) mem[k] <= '0;
      busy <= '0;
    end else begin
      for (int j = 0; j < NWRITE; j++)
        if (wen[j] && |waddr[j*ADDR_WIDTH +: ADDR_WIDTH]) begin
          mem[waddr[j*ADDR_WIDTH +: ADDR_WIDTH]]  <= wdata[j*DATA_WIDTH +: DATA_WIDTH];
          busy[waddr[j*ADDR_WIDTH +: ADDR_WIDTH]] <= 1'b0;
        end
      if (flush) busy <= '0;
      else if (alloc_en && alloc_ready && |alloc_addr) busy[alloc_addr] <= 1'b1;
    end
  end
  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic [DATA_WIDTH-1:0] rd;
    logic                  rr;
    assign ra = raddr[i*ADDR_WIDTH +: ADDR_WIDTH];
    // bypass is suppressed under reset so outputs stay at the cleared state
    always_comb begin
      rd = mem[ra];
      rr = !busy[ra];
      for (int j = 0; j < NWRITE; j++)
        if (BYPASS != 0 && rst_n && wen[j] && |ra && waddr[j*ADDR_WIDTH +: ADDR_WIDTH] == ra) begin
          rd = wdata[j*DATA_WIDTH +: DATA_WIDTH];
          rr = 1'b1;
        end
    end
    assign rdata[i*DATA_WIDTH +: DATA_WIDTH] = rd;
    assign rready[i] = rr;
  end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed vector table plus randomized run against an array-based scoreboard model
module tb_regfile_sb;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  wen;
  logic [4:0]  wa [2];
  logic [4:0]  ra [2];
  logic [63:0] wd [2];
  logic        ae, fl;
  logic [4:0]  aa;
  logic [9:0]   raddr, waddr;
  logic [127:0] wdata, rdata_b, rdata_n;
  logic [1:0]   rr_b, rr_n;
  logic         ar_b, ar_n;
  int total = 0, bad = 0;

  assign raddr = {ra[1], ra[0]};
  assign waddr = {wa[1], wa[0]};
  assign wdata = {wd[1], wd[0]};

  always #5 clk = ~clk;

  regfile_sb #(.NWRITE(2), .BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata_b), .rready(rr_b),
    .wen(wen), .waddr(waddr), .wdata(wdata), .alloc_en(ae), .alloc_addr(aa),
    .alloc_ready(ar_b), .flush(fl));

  regfile_sb #(.NWRITE(2), .BYPASS(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata_n), .rready(rr_n),
    .wen(wen), .waddr(waddr), .wdata(wdata), .alloc_en(ae), .alloc_addr(aa),
    .alloc_ready(ar_n), .flush(fl));

  logic [63:0] mem_m [32];
  logic [31:0] busy_m;

  task automatic mreset();
    for (int k = 0; k < 32; k++) mem_m[k] = '0;
    busy_m = '0;
  endtask

  task automatic mstep();
    logic [31:0] clr, set;
    clr = '0;
    set = '0;
    if (!rst_n) mreset();
    else begin
      for (int j = 0; j < 2; j++)
        if (wen[j] && wa[j] != 0) begin
          mem_m[wa[j]] = wd[j];
          clr[wa[j]] = 1'b1;
        end
      if (ae && aa != 0 && !busy_m[aa]) set[aa] = 1'b1;
      busy_m = fl ? '0 : ((busy_m & ~clr) | set);
    end
  endtask

  task automatic mread(input logic [4:0] a, input bit byp, output logic [63:0] d, output logic r);
    d = mem_m[a];
    r = !busy_m[a];
    if (byp && rst_n)
      for (int j = 0; j < 2; j++)
        if (wen[j] && wa[j] == a) begin
          d = wd[j];
          r = 1'b1;
        end
    if (a == 0) begin
      d = '0;
      r = 1'b1;
    end
  endtask

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    mstep();
    #1;
  endtask

  task automatic drive(input logic [1:0] w, input logic [4:0] a0, input logic [4:0] a1,
                       input logic [63:0] d0, input logic [63:0] d1, input logic e,
                       input logic [4:0] a, input logic f, input logic [4:0] r0, input logic [4:0] r1);
    wen = w; wa[0] = a0; wa[1] = a1; wd[0] = d0; wd[1] = d1;
    ae = e; aa = a; fl = f; ra[0] = r0; ra[1] = r1;
  endtask

  task automatic mchk();
    logic [63:0] d;
    logic r;
    for (int p = 0; p < 2; p++) begin
      mread(ra[p], 1'b1, d, r);
      chk("rnd_byp_rdata", rdata_b[p*64 +: 64], d);
      chk("rnd_byp_rready", 64'(rr_b[p]), 64'(r));
      mread(ra[p], 1'b0, d, r);
      chk("rnd_nobyp_rdata", rdata_n[p*64 +: 64], d);
      chk("rnd_nobyp_rready", 64'(rr_n[p]), 64'(r));
    end
    chk("rnd_alloc_ready", 64'(ar_b), 64'(!busy_m[aa]));
    chk("rnd_alloc_ready_nb", 64'(ar_n), 64'(!busy_m[aa]));
  endtask

  typedef struct {
    logic [1:0]  w;
    logic [4:0]  a0, a1;
    logic [63:0] d0, d1;
    logic        e;
    logic [4:0]  a;
    logic        f;
    logic [4:0]  r0, r1;
    logic [63:0] ed0;
    logic        er0;
    logic [63:0] ed1;
    logic        er1, ear;
    logic [63:0] nd0;
    logic        nr0;
  } vec_t;

  vec_t tv [20];

  initial begin
    tv[0]  = '{2'b01, 7, 0, 64'hDEAD_BEEF, 0, 0, 0, 0, 7, 7, 64'hDEAD_BEEF, 1, 64'hDEAD_BEEF, 1, 1, 0, 1};
    tv[1]  = '{2'b00, 0, 0, 0, 0, 0, 0, 0, 7, 7, 64'hDEAD_BEEF, 1, 64'hDEAD_BEEF, 1, 1, 64'hDEAD_BEEF, 1};
    tv[2]  = '{2'b01, 0, 0, 64'hFFFF, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 1};
    tv[3]  = '{2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 1};
    tv[4]  = '{2'b01, 3, 0, 64'h55, 0, 0, 0, 0, 3, 7, 64'h55, 1, 64'hDEAD_BEEF, 1, 1, 0, 1};
    tv[5]  = '{2'b00, 0, 0, 0, 0, 0, 0, 0, 3, 3, 64'h55, 1, 64'h55, 1, 1, 64'h55, 1};
    tv[6]  = '{2'b00, 0, 0, 0, 0, 1, 9, 0, 9, 9, 0, 1, 0, 1, 1, 0, 1};
    tv[7]  = '{2'b00, 0, 0, 0, 0, 1, 9, 0, 9, 9, 0, 0, 0, 0, 0, 0, 0};
    tv[8]  = '{2'b01, 9, 0, 64'h42, 0, 0, 9, 0, 9, 9, 64'h42, 1, 64'h42, 1, 0, 0, 0};
    tv[9]  = '{2'b00, 0, 0, 0, 0, 0, 9, 0, 9, 9, 64'h42, 1, 64'h42, 1, 1, 64'h42, 1};
    tv[10] = '{2'b01, 4, 0, 64'h11, 0, 1, 4, 0, 4, 4, 64'h11, 1, 64'h11, 1, 1, 0, 1};
    tv[11] = '{2'b00, 0, 0, 0, 0, 0, 4, 0, 4, 4, 64'h11, 0, 64'h11, 0, 0, 64'h11, 0};
    tv[12] = '{2'b11, 6, 6, 64'hA, 64'hB, 0, 0, 0, 6, 6, 64'hB, 1, 64'hB, 1, 1, 0, 1};
    tv[13] = '{2'b00, 0, 0, 0, 0, 0, 0, 0, 6, 6, 64'hB, 1, 64'hB, 1, 1, 64'hB, 1};
    tv[14] = '{2'b00, 0, 0, 0, 0, 1, 1, 0, 1, 1, 0, 1, 0, 1, 1, 0, 1};
    tv[15] = '{2'b00, 0, 0, 0, 0, 1, 2, 0, 1, 2, 0, 0, 0, 1, 1, 0, 0};
    tv[16] = '{2'b00, 0, 0, 0, 0, 1, 3, 0, 2, 1, 0, 0, 0, 0, 1, 0, 0};
    tv[17] = '{2'b00, 0, 0, 0, 0, 1, 10, 1, 3, 10, 64'h55, 0, 0, 1, 1, 64'h55, 0};
    tv[18] = '{2'b00, 0, 0, 0, 0, 0, 10, 0, 3, 10, 64'h55, 1, 0, 1, 1, 64'h55, 1};
    tv[19] = '{2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 1, 64'h11, 1, 1, 0, 1};
    mreset();
    rst_n = 1'b0;
    drive(2'b01, 5, 0, 64'h99, 0, 1, 5, 0, 5, 5);
    #3;
    chk("rst_rdata", rdata_b[63:0], 0);
    chk("rst_rready", 64'(rr_b), 64'h3);
    chk("rst_alloc_ready", 64'(ar_b), 1);
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 16; k++) begin
      drive(0, 0, 0, 0, 0, 0, 5'(k), 0, 5'(2*k), 5'(2*k+1));
      #3;
      chk("post_rst_rdata0", rdata_b[63:0], 0);
      chk("post_rst_rdata1", rdata_b[127:64], 0);
      chk("post_rst_rready", 64'({rr_b, rr_n}), 64'hF);
      chk("post_rst_alloc_ready", 64'(ar_b), 1);
      tick();
    end
    drive(2'b01, 5, 0, 64'h1234, 0, 0, 0, 0, 5, 5);
    #3;
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 5, 5);
    #1;
    chk("x5_written", rdata_n[63:0], 64'h1234);
    rst_n = 1'b0;
    mreset();
    #1;
    chk("async_rst_byp", rdata_b[63:0], 0);
    chk("async_rst_nobyp", rdata_n[63:0], 0);
    tick();
    rst_n = 1'b1;
    #3;
    tick();
    for (int k = 0; k < 20; k++) begin
      drive(tv[k].w, tv[k].a0, tv[k].a1, tv[k].d0, tv[k].d1, tv[k].e, tv[k].a, tv[k].f, tv[k].r0, tv[k].r1);
      #3;
      chk($sformatf("vec%0d_rdata0", k), rdata_b[63:0], tv[k].ed0);
      chk($sformatf("vec%0d_rready0", k), 64'(rr_b[0]), 64'(tv[k].er0));
      chk($sformatf("vec%0d_rdata1", k), rdata_b[127:64], tv[k].ed1);
      chk($sformatf("vec%0d_rready1", k), 64'(rr_b[1]), 64'(tv[k].er1));
      chk($sformatf("vec%0d_alloc_ready", k), 64'(ar_b), 64'(tv[k].ear));
      chk($sformatf("vec%0d_nobyp_rdata0", k), rdata_n[63:0], tv[k].nd0);
      chk($sformatf("vec%0d_nobyp_rready0", k), 64'(rr_n[0]), 64'(tv[k].nr0));
      tick();
    end
    for (int n = 0; n < 400; n++) begin
      rst_n = 1'b1;
      wen = 2'($urandom_range(0, 3));
      for (int p = 0; p < 2; p++) begin
        wa[p] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
        ra[p] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
        wd[p] = {$urandom, $urandom};
      end
      ae = 1'($urandom_range(0, 1));
      aa = 5'($urandom_range(0, 7));
      fl = ($urandom_range(0, 15) == 0);
      if (n == 200) begin
        #1;
        rst_n = 1'b0;
        mreset();
        #2;
      end else #3;
      mchk();
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
